// File: rtl/core_wb_arbiter.sv
// Writeback port arbiter: LSU (buffered/bypass) > round-robin{MDU, EXU}.
// Optional counters: define WB_PERF_CNT_EN for perf_wb_cnt/perf_conflict_cnt.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

module core_wb_arbiter #(
    parameter int XLEN          = `CORE_XLEN,
    parameter int LSU_BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_hold,
    input  logic            lsu_resp_valid,
    input  logic [4:0]      lsu_resp_rd,
    input  logic [XLEN-1:0] lsu_resp_data,
    output logic            lsu_buf_full,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_commit,
`ifdef WB_PERF_CNT_EN
    output logic [63:0]     perf_wb_cnt,
    output logic [63:0]     perf_conflict_cnt,
`endif
    output logic            wb_ovf_err
);

    localparam int PW = $clog2(LSU_BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      buf_rd   [LSU_BUF_DEPTH];
    logic [XLEN-1:0] buf_data [LSU_BUF_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            rr;

    logic            buf_empty, lsu_pend, lsu_grant;
    logic            enq_req, enq, deq, ovf, arb_ok, any_grant;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    assign buf_empty    = (count == '0);
    assign lsu_buf_full = (count == CW'(LSU_BUF_DEPTH));
    assign lsu_pend     = !buf_empty || lsu_resp_valid;
    assign lsu_grant    = !wb_hold && lsu_pend;
    assign deq          = lsu_grant && !buf_empty;

    // A response is buffered unless it goes straight out via the bypass.
    assign enq_req = lsu_resp_valid && !(lsu_grant && buf_empty);
    assign enq     = enq_req && (!lsu_buf_full || deq);
    assign ovf     = enq_req && lsu_buf_full && !deq;

    assign arb_ok    = !wb_hold && !lsu_pend;
    assign mdu_ready = arb_ok && mdu_valid && (!exu_valid || !rr);
    assign exu_ready = arb_ok && exu_valid && (!mdu_valid || rr);
    assign any_grant = lsu_grant || mdu_ready || exu_ready;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (lsu_grant && buf_empty) begin
            sel_rd   = lsu_resp_rd;
            sel_data = lsu_resp_data;
        end else if (lsu_grant) begin
            sel_rd   = buf_rd[rd_ptr];
            sel_data = buf_data[rd_ptr];
        end else if (mdu_ready) begin
            sel_rd   = mdu_rd;
            sel_data = mdu_data;
        end else if (exu_ready) begin
            sel_rd   = exu_rd;
            sel_data = exu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            buf_rd[wr_ptr]   <= lsu_resp_rd;
            buf_data[wr_ptr] <= lsu_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rr         <= 1'b0;
            wb_ovf_err <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(enq) - CW'(deq);
            if (ovf) wb_ovf_err <= 1'b1;
            if (mdu_ready && exu_valid) rr <= 1'b1;
            else if (exu_ready && mdu_valid) rr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en     <= 1'b0;
            wb_commit <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            wb_commit <= any_grant;
            wb_en     <= any_grant && (sel_rd != 5'd0);
            if (any_grant) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [1:0] nsrc;
    assign nsrc = 2'(lsu_pend) + 2'(mdu_valid) + 2'(exu_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_wb_cnt       <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (wb_commit) perf_wb_cnt <= perf_wb_cnt + 64'd1;
            if (!wb_hold && nsrc >= 2'd2)
                perf_conflict_cnt <= perf_conflict_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Scoreboard bench for core_wb_arbiter: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_core_wb_arbiter;

    localparam int XLEN = 32;
    localparam int D    = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_hold = 1'b0;
    logic            lsu_resp_valid = 1'b0;
    logic [4:0]      lsu_resp_rd = '0;
    logic [XLEN-1:0] lsu_resp_data = '0;
    logic            lsu_buf_full;
    logic            mdu_valid = 1'b0;
    logic            mdu_ready;
    logic [4:0]      mdu_rd = '0;
    logic [XLEN-1:0] mdu_data = '0;
    logic            exu_valid = 1'b0;
    logic            exu_ready;
    logic [4:0]      exu_rd = '0;
    logic [XLEN-1:0] exu_data = '0;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_commit;
    logic            wb_ovf_err;

    core_wb_arbiter #(.XLEN(XLEN), .LSU_BUF_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .wb_hold(wb_hold),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rd(lsu_resp_rd),
        .lsu_resp_data(lsu_resp_data), .lsu_buf_full(lsu_buf_full),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_rd(exu_rd), .exu_data(exu_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_commit(wb_commit), .wb_ovf_err(wb_ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        en;
    } wr_t;

    ent_t lq[$];
    wr_t  exq[$];
    bit   m_rr, m_ovf, g_mdu, g_exu;
    int   cyc, errors, checks;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One cycle: drive inputs, predict grant from queue model, check.
    task automatic step(input logic h,
                        input logic lv, input logic [4:0] lrd,
                        input logic [31:0] ld,
                        input logic mv, input logic [4:0] mrd,
                        input logic [31:0] md,
                        input logic ev, input logic [4:0] erd,
                        input logic [31:0] ed);
        bit   src, em, ee, gw;
        ent_t e;
        @(posedge clk);
        cyc++;
        #1;
        wb_hold = h;
        lsu_resp_valid = lv; lsu_resp_rd = lrd; lsu_resp_data = ld;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
        exu_valid = ev; exu_rd = erd; exu_data = ed;
        #1;
        chk("lsu_buf_full", lsu_buf_full, lq.size() == D);
        chk("wb_ovf_err", wb_ovf_err, m_ovf);
        src = (lq.size() > 0) || lv;
        em = 0; ee = 0; gw = 0;
        e = '{rd: 5'd0, data: 32'd0};
        if (!h && src) begin
            gw = 1;
            if (lq.size() > 0) begin
                e = lq.pop_front();
                if (lv) lq.push_back('{rd: lrd, data: ld});
            end else begin
                e = '{rd: lrd, data: ld};
            end
        end else begin
            if (lv) begin
                if (lq.size() < D) lq.push_back('{rd: lrd, data: ld});
                else m_ovf = 1;
            end
            if (!h) begin
                if (mv && ev) begin
                    if (m_rr) ee = 1;
                    else em = 1;
                    m_rr = !m_rr;
                end else begin
                    em = mv;
                    ee = ev;
                end
            end
        end
        chk("mdu_ready", mdu_ready, em);
        chk("exu_ready", exu_ready, ee);
        if (em) begin e = '{rd: mrd, data: md}; gw = 1; end
        if (ee) begin e = '{rd: erd, data: ed}; gw = 1; end
        if (gw)
            exq.push_back('{cyc: cyc + 1, rd: e.rd, data: e.data,
                            en: e.rd != 5'd0});
        g_mdu = em;
        g_exu = ee;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 0;
        wb_hold = 0; lsu_resp_valid = 0; mdu_valid = 0; exu_valid = 0;
        lq.delete();
        exq.delete();
        m_rr = 0;
        m_ovf = 0;
        #1;
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_commit", wb_commit, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_buf_full", lsu_buf_full, 0);
        chk("rst_ovf_err", wb_ovf_err, 0);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1;
    endtask

    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wb_commit) begin
                    if (exq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: got rd=%0d expected none",
                                 wb_rd);
                    end else begin
                        w = exq.pop_front();
                        chk("wb_cycle", 64'(cyc), 64'(w.cyc));
                        chk("wb_rd", wb_rd, w.rd);
                        chk("wb_data", wb_data, w.data);
                        chk("wb_en", wb_en, w.en);
                    end
                end else begin
                    chk("wb_en_idle", wb_en, 0);
                    if (exq.size() > 0 && exq[0].cyc <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_commit: got none expected rd=%0d",
                                 exq[0].rd);
                        void'(exq.pop_front());
                    end
                end
            end
        end
    end

    initial begin : driver
        logic        mv, ev, lv, h;
        logic [4:0]  mrd, erd, lrd;
        logic [31:0] md, ed, ld;
        do_reset();
        // EXU alone
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234);
        idle(2);
        // MDU/EXU contention alternates
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 1, 5'd7, 32'h100 + i, 1, 5'd9, 32'h200 + i);
        idle(2);
        // LSU beats EXU, EXU follows
        step(0, 1, 3, 32'hAAAA, 0, 0, 0, 1, 4, 32'hBBBB);
        step(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hBBBB);
        idle(2);
        // hold fills FIFO, release drains in order
        step(1, 1, 10, 32'hA0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 11, 32'hB0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // overflow while held, sticky until reset
        step(1, 1, 12, 32'hC0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 13, 32'hC1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 14, 32'hC2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle(2);
        // rd==0 commits without write enable
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
        idle(2);
        // randomized traffic with handshake-respecting producers
        mv = 0; ev = 0; mrd = 0; erd = 0; md = 0; ed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                mv = 0;
                ev = 0;
            end
            h = ($urandom_range(0, 4) == 0);
            lv = ($urandom_range(0, 2) == 0) && (lq.size() < D);
            lrd = 5'($urandom);
            ld = $urandom;
            if (!mv && $urandom_range(0, 1) == 1) begin
                mv = 1; mrd = 5'($urandom); md = $urandom;
            end
            if (!ev && $urandom_range(0, 1) == 1) begin
                ev = 1; erd = 5'($urandom); ed = $urandom;
            end
            step(h, lv, lrd, ld, mv, mrd, md, ev, erd, ed);
            if (g_mdu) mv = 0;
            if (g_exu) ev = 0;
        end
        idle(8);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
